// File: rtl/axi_wr_arbiter.sv
// Purpose : shares one axi_wr_master write engine between two burst requesters.
// Latency : request seen in IDLE cycle T -> ackN/m_wr_trig at T+1; m_wr_done at D -> doneN at D+1.
// Backpres: one burst in flight; new requests wait for IDLE, m_wr_ready and init_end.
//
// Build option: define WR_ARB_RR_EN for round-robin between simultaneous
// requests (port 0 wins the first contest after reset). Left undefined, port 0
// has fixed priority and the round-robin pointer is not built.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   init_end                DDR2 initialisation complete; no grant while low
//   reqN/lenN/addrN/dataN   requester N: level request, beat count, address, write data
//   ackN/data_enN/doneN     requester N: request taken, data strobe, burst complete
//   busy                    a burst is being issued or is in flight
//   m_wr_*                  interface to the shared write master
module axi_wr_arbiter #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_end,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [7:0]            len0,
    input  logic [7:0]            len1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  data_en0,
    output logic                  data_en1,
    output logic                  done0,
    output logic                  done1,
    output logic                  busy,
    output logic                  m_wr_trig,
    output logic [7:0]            m_wr_len,
    output logic [ADDR_WIDTH-1:0] m_wr_addr,
    output logic [DATA_WIDTH-1:0] m_wr_data,
    input  logic                  m_wr_data_en,
    input  logic                  m_wr_ready,
    input  logic                  m_wr_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;
    logic                    done0_q, done0_d;
    logic                    done1_q, done1_d;
    logic                    trig_q, trig_d;
    logic [7:0]              len_q, len_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;

    logic                    cand0, cand1;
    logic                    pick1;
    logic                    can_grant;
    logic [7:0]              win_len;
    logic [ADDR_WIDTH-1:0]   win_addr;

    // The requester still holds reqN during the cycle its ackN is showing.
    // Masking it here stops a zero-length request (which leaves us in IDLE)
    // from being taken a second time.
    assign cand0 = req0 & ~ack0_q;
    assign cand1 = req1 & ~ack1_q;

`ifdef WR_ARB_RR_EN
    logic last_q, last_d;   // 1: port 1 was the last port granted

    // Port 1 wins when alone, or when both ask and port 0 was served last.
    assign pick1 = cand1 & (~cand0 | ~last_q);
`else
    assign pick1 = cand1 & ~cand0;
`endif

    assign win_len   = pick1 ? len1  : len0;
    assign win_addr  = pick1 ? addr1 : addr0;
    assign can_grant = (state_q == S_IDLE) & init_end & m_wr_ready & (cand0 | cand1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        len_d   = len_q;
        addr_d  = addr_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        trig_d  = 1'b0;
`ifdef WR_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (can_grant) begin
                    ack0_d = ~pick1;
                    ack1_d = pick1;
`ifdef WR_ARB_RR_EN
                    last_d = pick1;
`endif
                    if (win_len == 8'd0) begin
                        // Nothing to move: acknowledge and complete at once,
                        // without waking the master.
                        done0_d = ~pick1;
                        done1_d = pick1;
                    end else begin
                        trig_d  = 1'b1;
                        grant_d = pick1;
                        len_d   = win_len;
                        addr_d  = win_addr;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (m_wr_done) begin
                    done0_d = ~grant_q;
                    done1_d = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            trig_q  <= 1'b0;
            len_q   <= 8'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            trig_q  <= trig_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
        end
    end

`ifdef WR_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign busy      = (state_q != S_IDLE);
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign m_wr_trig = trig_q;
    assign m_wr_len  = len_q;
    assign m_wr_addr = addr_q;

    // Strobe and data path follow the held grant; nothing is steered in IDLE.
    assign data_en0  = m_wr_data_en & ~grant_q & busy;
    assign data_en1  = m_wr_data_en &  grant_q & busy;
    assign m_wr_data = grant_q ? data1 : data0;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
`timescale 1ns/1ps
module tb_axi_wr_arbiter;
    localparam int AW = 26;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          init_end, m_wr_data_en, m_wr_ready, m_wr_done;
    logic          req_b  [2];
    logic [7:0]    len_b  [2];
    logic [AW-1:0] addr_b [2];
    logic [DW-1:0] data_b [2];
    logic          ack0, ack1, data_en0, data_en1, done0, done1, busy, m_wr_trig;
    logic [7:0]    m_wr_len;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;

    axi_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .init_end(init_end),
        .req0(req_b[0]), .req1(req_b[1]), .len0(len_b[0]), .len1(len_b[1]),
        .addr0(addr_b[0]), .addr1(addr_b[1]), .data0(data_b[0]), .data1(data_b[1]),
        .ack0(ack0), .ack1(ack1), .data_en0(data_en0), .data_en1(data_en1),
        .done0(done0), .done1(done1), .busy(busy), .m_wr_trig(m_wr_trig),
        .m_wr_len(m_wr_len), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
        .m_wr_data_en(m_wr_data_en), .m_wr_ready(m_wr_ready), .m_wr_done(m_wr_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Environment: two requesters and a simple write master.
    bit rand_on, init_val;
    bit rq [2], drop [2], outst [2], persist [2];
    int txn [2], beat [2], strobes [2], served_len [2];
    bit mst_act;
    int mst_rem, mst_dly;

    // Reference model: one burst at a time, outputs expected for the next cycle.
    bit            mdl_busy, mdl_issue;
    int            mdl_owner;
`ifdef WR_ARB_RR_EN
    int            mdl_last;
`endif
    bit            exp_ack [2], exp_done [2];
    bit            exp_trig, exp_busy;
    logic [7:0]    exp_len;
    logic [AW-1:0] exp_addr;
    int            grant_log [$];

    function automatic logic [DW-1:0] word(input int p);
        logic [31:0] w;
        w = (32'(p) << 28) | ((32'(txn[p]) & 32'hfff) << 16) | (32'(beat[p]) & 32'hffff);
        return DW'(w);
    endfunction

    task automatic raise(input int p, input int l, input logic [AW-1:0] a);
        rq[p] = 1'b1; outst[p] = 1'b1; drop[p] = 1'b0;
        txn[p]++; beat[p] = 0;
        len_b[p] = 8'(l); addr_b[p] = a;
    endtask

    task automatic clear_env();
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0; drop[p] = 0; outst[p] = 0; persist[p] = 0;
            exp_ack[p] = 0; exp_done[p] = 0; strobes[p] = 0; served_len[p] = 0;
            req_b[p] = 1'b0;
        end
        mst_act = 0; mst_rem = 0; mst_dly = 0;
        mdl_busy = 0; mdl_issue = 0; mdl_owner = 0;
`ifdef WR_ARB_RR_EN
        mdl_last = 1;
`endif
        exp_trig = 0; exp_busy = 0;
        grant_log.delete();
        m_wr_data_en = 1'b0; m_wr_done = 1'b0; m_wr_ready = 1'b0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle();
        bit   c0, c1, en;
        int   w;
        logic ackv [2], donev [2], denv [2];
        ackv[0] = ack0; ackv[1] = ack1; donev[0] = done0; donev[1] = done1;

        check_eq("ack0", ack0, exp_ack[0]);
        check_eq("ack1", ack1, exp_ack[1]);
        check_eq("done0", done0, exp_done[0]);
        check_eq("done1", done1, exp_done[1]);
        check_eq("trig", m_wr_trig, exp_trig);
        check_eq("busy", busy, exp_busy);
        if (exp_trig) begin
            check_eq("wr_len", m_wr_len, exp_len);
            check_eq("wr_addr", m_wr_addr, exp_addr);
        end
        for (int p = 0; p < 2; p++)
            if (exp_done[p]) check_eq(p == 0 ? "beats0" : "beats1", strobes[p], served_len[p]);

        for (int p = 0; p < 2; p++) begin
            if (drop[p]) begin rq[p] = 0; drop[p] = 0; end
            else if (ackv[p] && rq[p]) drop[p] = 1;
            if (donev[p]) outst[p] = 0;
        end
        if (m_wr_trig && !mst_act) begin
            mst_act = 1; mst_rem = int'(m_wr_len); mst_dly = $urandom_range(0, 3);
        end

        for (int p = 0; p < 2; p++) begin
            if (!rq[p] && !outst[p]) begin
                if (rand_on ? ($urandom_range(0, 3) == 0) : persist[p])
                    raise(p, rand_on ? int'($urandom_range(0, 6)) : 4, AW'($urandom));
            end else if (rand_on && rq[p] && !drop[p] && !exp_ack[p] && $urandom_range(0, 49) == 0) begin
                rq[p] = 0; outst[p] = 0;
            end
            req_b[p]  = rq[p];
            data_b[p] = word(p);
        end
        if (mst_act) begin
            m_wr_ready = 1'b0; m_wr_done = 1'b0; m_wr_data_en = 1'b0;
            if (mst_rem > 0) m_wr_data_en = ($urandom_range(0, 3) != 0);
            else if (mst_dly > 0) mst_dly--;
            else begin m_wr_done = 1'b1; mst_act = 0; end
        end else begin
            m_wr_ready   = rand_on ? ($urandom_range(0, 7) != 0) : 1'b1;
            m_wr_data_en = rand_on && ($urandom_range(0, 9) == 0);
            m_wr_done    = rand_on && ($urandom_range(0, 15) == 0);
        end
        if (rand_on) begin
            if (init_val ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 9) == 0))
                init_val = !init_val;
        end
        init_end = init_val;
        #1;

        denv[0] = data_en0; denv[1] = data_en1;
        for (int p = 0; p < 2; p++) begin
            en = m_wr_data_en && mdl_busy && (mdl_owner == p);
            check_eq(p == 0 ? "data_en0" : "data_en1", denv[p], en);
            if (en) begin
                check_eq("wr_data", m_wr_data, word(p));
                strobes[p]++; beat[p]++;
            end
        end
        if (mst_act && m_wr_data_en) mst_rem--;

        c0 = rq[0] && !exp_ack[0];
        c1 = rq[1] && !exp_ack[1];
        exp_ack[0] = 0; exp_ack[1] = 0; exp_done[0] = 0; exp_done[1] = 0; exp_trig = 0;
        if (!mdl_busy) begin
            if (init_val && m_wr_ready && (c0 || c1)) begin
`ifdef WR_ARB_RR_EN
                w = (c0 && c1) ? (mdl_last == 1 ? 0 : 1) : (c0 ? 0 : 1);
                mdl_last = w;
`else
                w = c0 ? 0 : 1;
`endif
                exp_ack[w] = 1;
                grant_log.push_back(w);
                served_len[w] = int'(len_b[w]);
                strobes[w] = 0;
                if (len_b[w] == 8'd0) exp_done[w] = 1;
                else begin
                    exp_trig = 1; exp_len = len_b[w]; exp_addr = addr_b[w];
                    mdl_busy = 1; mdl_issue = 1; mdl_owner = w;
                end
            end
        end else if (mdl_issue) mdl_issue = 0;
        else if (m_wr_done) begin
            exp_done[mdl_owner] = 1; mdl_busy = 0;
        end
        exp_busy = mdl_busy;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_outs", {ack0, ack1, done0, done1, busy, m_wr_trig, data_en0, data_en1}, 8'h00);
        check_eq("rst_len", m_wr_len, 8'h00);
        check_eq("rst_addr", m_wr_addr, '0);
        clear_env();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n, k;
        bit seen1;
        int exp_order [4];
        rst_n = 1'b0; init_val = 0; rand_on = 0; init_end = 1'b0;
        for (int p = 0; p < 2; p++) begin
            len_b[p] = 8'd0; addr_b[p] = '0; data_b[p] = '0; txn[p] = 0; beat[p] = 0;
        end
        clear_env();
        @(posedge clk); #1;
        apply_reset();

        // Single request, len 8 at 0x100.
        init_val = 1;
        raise(0, 8, AW'(32'h100));
        cycle();
        check_eq("t1_ack0", ack0, 1'b1);
        check_eq("t1_trig", m_wr_trig, 1'b1);
        check_eq("t1_addr", m_wr_addr, AW'(32'h100));
        check_eq("t1_len", m_wr_len, 8'd8);
        n = 0;
        repeat (40) begin cycle(); n += int'(done0); end
        check_eq("t1_done_cnt", n, 1);
        check_eq("t1_strobes", strobes[0], 8);

        // init_end low blocks the grant.
        init_val = 0;
        raise(1, 3, AW'(32'h2000));
        n = 0;
        repeat (20) begin cycle(); n += int'(ack1) + int'(m_wr_trig); end
        check_eq("t2_blocked", n, 0);
        init_val = 1;
        cycle();
        check_eq("t2_ack1", ack1, 1'b1);
        repeat (20) cycle();

        // Zero-length request.
        raise(0, 0, AW'(32'h40));
        cycle();
        check_eq("t3_ack0", ack0, 1'b1);
        check_eq("t3_done0", done0, 1'b1);
        check_eq("t3_trig", m_wr_trig, 1'b0);
        check_eq("t3_busy", busy, 1'b0);
        repeat (6) cycle();

        // Reset during WAIT of a len 16 burst, then a fresh request.
        raise(0, 16, AW'(32'h3000));
        k = 0;
        while (!(mdl_busy && !mdl_issue) && k < 50) begin cycle(); k++; end
        repeat (3) cycle();
        check_eq("t4_busy", busy, 1'b1);
        apply_reset();
        raise(1, 5, AW'(32'h4000));
        n = 0;
        repeat (30) begin cycle(); n += int'(ack1); end
        check_eq("t4_post_ack1", n, 1);

        // Both ports requesting continuously, len 4.
        apply_reset();
        persist[0] = 1; persist[1] = 1;
        k = 0;
        while (grant_log.size() < 4 && k < 300) begin cycle(); k++; end
        check_eq("t5_grants", grant_log.size() >= 4, 1'b1);
`ifdef WR_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++)
            if (i < grant_log.size()) check_eq("t5_order", grant_log[i], exp_order[i]);
        persist[0] = 0;
        seen1 = 0; k = 0;
        while (!seen1 && k < 200) begin cycle(); if (ack1) seen1 = 1; k++; end
        check_eq("t5_port1", seen1, 1'b1);
        persist[1] = 0;
        repeat (40) cycle();

        // Randomised traffic against the model.
        rand_on = 1;
        repeat (3000) cycle();
        rand_on = 0; init_val = 1;
        repeat (80) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
